// File: rtl/dbus_responder_if.sv
// dbus_responder_if: groups the core data-bus signals and the console
// drain handshake used by dbus_responder.
//   master : the core / host side (drives we, a, wd, con_ready)
//   slave  : the responder (drives rd, con_valid, con_data)
interface dbus_responder_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    modport master (
        output we, a, wd, con_ready,
        input  rd, con_valid, con_data
    );

    modport slave (
        input  we, a, wd, con_ready,
        output rd, con_valid, con_data
    );
endinterface

// File: rtl/dbus_responder.sv
// dbus_responder: data-memory side responder for the single-cycle ARM core.
// Provides a word-addressed data RAM, a free-running cycle counter and a
// byte-wide console FIFO drained through a valid/ready handshake.
//
// Console handshake: a byte transfers at every rising edge where con_valid
// and con_ready are both high; con_valid/con_data depend only on FIFO state
// and never on the same-cycle bus request.
//
// Optional feature macro: DBUS_CYCLE_COUNTER_EN
//   defined   -> 32-bit cycle counter readable at 0x100
//   undefined -> no counter flops, 0x100 reads as 0
//
// Address map (byte addresses, a[1:0] ignored):
//   0x000 .. 4*RAM_WORDS-1 : RAM (read/write)
//   0x100 CYCLE            : read-only
//   0x104 CONSOLE          : write pushes wd[7:0], reads 0
//   0x108 STATUS           : {count[15:8], overflow[2], empty[1], full[0]},
//                            write wd[2]=1 clears overflow
module dbus_responder #(
    parameter int DEPTH     = 4,
    parameter int RAM_WORDS = 64
) (
    input logic             clk,
    input logic             reset,
    dbus_responder_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int IW = $clog2(RAM_WORDS);

    // Word addresses of the register block.
    localparam logic [29:0] WADDR_CYCLE   = 30'h40;
    localparam logic [29:0] WADDR_CONSOLE = 30'h41;
    localparam logic [29:0] WADDR_STATUS  = 30'h42;

    // Address decode on the word address.
    logic in_ram, is_cycle, is_console, is_status;
    assign in_ram     = (bus.a[31:2] < 30'(RAM_WORDS));
    assign is_cycle   = (bus.a[31:2] == WADDR_CYCLE);
    assign is_console = (bus.a[31:2] == WADDR_CONSOLE);
    assign is_status  = (bus.a[31:2] == WADDR_STATUS);

    // Byte lane bits take no part in decoding.
    logic unused_a;
    assign unused_a = ^bus.a[1:0];

    // ---------------- data RAM (not reset) ----------------
    logic [31:0] ram [RAM_WORDS];

    // RAM write lands at the edge; same-cycle reads see the old word.
    always_ff @(posedge clk) begin
        if (bus.we && in_ram) begin
            ram[bus.a[IW+1:2]] <= bus.wd;
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_val;
`ifdef DBUS_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    assign cycle_d = cycle_q + 32'd1;

    // Free-running counter, wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // ---------------- console FIFO ----------------
    logic [7:0]    fifo_mem [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic full, empty, push_req, push_ok, pop, ovf_set, ovf_clr;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop      = !empty && bus.con_ready;
    assign push_req = bus.we && is_console;
    // A push into a full FIFO is accepted only if a pop frees a slot at the same edge.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = bus.we && is_status && bus.wd[2];

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push_ok) begin
            tail_d = tail_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Set takes priority over a simultaneous clear.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage; stale entries are masked by the count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[tail_q] <= bus.wd[7:0];
        end
    end

    assign bus.con_valid = !empty;
    assign bus.con_data  = empty ? 8'h00 : fifo_mem[head_q];

    // ---------------- read mux ----------------
    logic [31:0] status_val;
    assign status_val = {16'h0000, 8'(count_q), 5'b00000, ovf_q, empty, full};

    // Combinational read path from the address.
    always_comb begin
        bus.rd = 32'h0000_0000;
        if (in_ram) begin
            bus.rd = ram[bus.a[IW+1:2]];
        end else if (is_cycle) begin
            bus.rd = cycle_val;
        end else if (is_status) begin
            bus.rd = status_val;
        end
    end
endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-bus responder for the single-cycle ARM core. It sits on the data-memory side of `top`, answering the core's `MemWrite` / `DataAdr` / `WriteData` / `ReadData` port. It provides a 64-word data RAM, a free-running cycle counter, and a byte-wide console FIFO that a testbench or host drains through a valid/ready handshake. Reads are combinational, because the core completes loads in the same cycle; all state updates occur on the rising clock edge.

## Interface
- `DEPTH`, 4: console FIFO entries; power of two, 2..16.
- `RAM_WORDS`, 64: data RAM size in 32-bit words; region is 0x000 to 4*RAM_WORDS-1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `we` input 1: write strobe from the core (`MemWrite`).
- `a` input 32: byte address (`DataAdr`); `a[1:0]` ignored, all accesses are word accesses.
- `wd` input 32: write data (`WriteData`).
- `rd` output 32: read data (`ReadData`), combinational from `a`.
- `con_valid` output 1: FIFO head holds a byte.
- `con_data` output 8: FIFO head byte.
- `con_ready` input 1: consumer accepts the head byte this cycle.

## Operation
- Address map:
  - `0x000` to `4*RAM_WORDS-1`: RAM, read/write.
  - `0x100` CYCLE: read-only; writes are ignored.
  - `0x104` CONSOLE: write-only; a write pushes `wd[7:0]`; a read returns 0.
  - `0x108` STATUS: read/write-1-to-clear.
  - Any other address: reads return 0, writes are ignored.
- RAM behaviour:
  - Index is `a[7:2]`.
  - Contents are not reset and are X until written.
  - A write lands at the clock edge; a read in the same cycle returns the old value.
- STATUS read value:
  - `[0]` full.
  - `[1]` empty.
  - `[2]` overflow, sticky.
  - `[15:8]` count (0..DEPTH).
  - All other bits are 0.
- STATUS write: `wd[2]=1` clears overflow. Other bits are ignored.
- Console FIFO is a circular buffer with head/tail pointers and a count.
  - Push = `we` & address is CONSOLE.
  - Pop = `con_valid & con_ready`.
  - Push and pop with `0<count<DEPTH`: both occur, count unchanged.
  - Push when full without pop: byte dropped, overflow set.
  - Push when full with pop: both occur, no overflow.
  - Pop when empty: cannot occur, because `con_valid=0`.
  - Pointers wrap modulo DEPTH.
- Overflow set and clear in the same cycle: set wins.
- Outputs:
  - `con_valid = (count != 0)`.
  - `con_data` = entry at head; 0 when empty.
  - Neither depends combinationally on `we`, `a` or `wd`.

## Timing
- `rd`: zero-latency combinational path from `a` (plus RAM/register state).
- Push is visible on `con_valid`/STATUS one cycle after the write cycle. A byte pushed into an empty FIFO appears on `con_data` at the next edge.
- Pop: the head advances at the edge where `con_valid & con_ready` is sampled high. The next byte is presented the following cycle, giving back-to-back throughput of 1 byte/cycle.
- Reset (asserted at any time, including mid-transfer):
  - count=0, head=tail=0, overflow=0, cycle counter=0.
  - `con_valid=0`, `con_data=0`.
  - `rd` reflects reset state: CYCLE reads 0, STATUS reads 0x0000_0002.
- Cycle counter: +1 on every edge while reset is low; wraps 0xFFFF_FFFF to 0.

## Configuration
- `DBUS_CYCLE_COUNTER_EN` defined: 32-bit counter present, as described above.
- Not defined:
  - No counter flops.
  - CYCLE reads return 0; writes are ignored.
  - All other behaviour is identical.

## Test plan
- RAM write/read:
  - Write 0x0000_0007 to 0x64; the same-cycle read returns the old value.
  - The next-cycle read of 0x64 returns 0x0000_0007.
  - Read 0x66 returns 0x0000_0007 (`a[1:0]` ignored).
- FIFO fill and drain:
  - With `con_ready=0`, push 0x41, 0x42, 0x43, 0x44 → STATUS = 0x0000_0401, `con_data=0x41`.
  - Raise `con_ready` → 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then `con_valid=0`, STATUS = 0x0000_0002.
- Overflow:
  - Fill 4 entries, then push 0x55 with `con_ready=0` → 0x55 dropped, STATUS = 0x0000_0405.
  - Write 0x4 to STATUS → STATUS = 0x0000_0401.
  - Full + simultaneous push/pop → count stays 4, overflow stays 0, new byte is the last drained.
- Cycle counter:
  - Release reset, wait 10 edges → CYCLE reads 10.
  - Force the counter to 0xFFFF_FFFF → next read 0.
  - Without `DBUS_CYCLE_COUNTER_EN` → always 0.
- Reset mid-operation:
  - Assert `reset` asynchronously with 3 entries queued and overflow set → `con_valid` drops immediately (no clock edge), STATUS = 0x0000_0002.
- Unmapped access:
  - Write 0xFFFF_FFFF to 0x200 → no state change; read 0x200 returns 0.
  - Read 0x104 returns 0.
